// File: rtl/counter_pkg.sv
// Shared types and constants for the counter controller.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter datapath: counts 0..limit while enabled, pulses wrap on limit->0.
module mod_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             zero,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (zero) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            if (count == limit) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/one-shot controller around a modulo counter with a cfg handshake.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    state_t           state, state_d;
    logic [WIDTH-1:0] limit, limit_d;
    logic             mode, mode_d;
    logic             enable, zero;
    logic             xfer, go, at_limit;

    assign xfer     = cfg_valid & cfg_ready;
    // stop outranks start even in states where stop itself does nothing
    assign go       = start & ~stop;
    assign at_limit = (count == limit);

    always_comb begin
        state_d = state;
        limit_d = limit;
        mode_d  = mode;
        enable  = 1'b0;
        zero    = 1'b0;
        if (clear) begin
            state_d = StIdle;
            zero    = 1'b1;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (xfer) begin
                        limit_d = cfg_limit;
                        mode_d  = cfg_mode;
                        zero    = 1'b1;
                        state_d = StIdle;
                    end
                    if (go) begin
                        state_d = StRun;
                        zero    = 1'b1;
                    end
                end
                StRun: begin
                    enable = 1'b1;
                    if (stop) begin
                        state_d = StPause;
                    end else if (at_limit && mode == MODE_ONESHOT) begin
                        state_d = StDone;
                    end
                end
                StPause: begin
                    if (go) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            limit     <= '1;
            mode      <= MODE_PERIODIC;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_d;
            limit     <= limit_d;
            mode      <= mode_d;
            busy      <= (state_d == StRun) || (state_d == StPause);
            done      <= (state_d == StDone);
            cfg_ready <= (state_d == StIdle) || (state_d == StDone);
        end
    end

    mod_counter #(
        .WIDTH(WIDTH)
    ) u_mod_counter (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .zero  (zero),
        .limit (limit),
        .count (count),
        .wrap  (wrap)
    );

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed scenarios plus randomized traffic.
module tb_counter_ctrl;

    localparam int W = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         cfg_valid, cfg_ready, cfg_mode;
    logic [W-1:0] cfg_limit;
    logic         start, stop, clear;
    logic [W-1:0] count;
    logic         wrap, busy, done;

    counter_ctrl #(
        .WIDTH(W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit),
        .cfg_mode (cfg_mode),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .count    (count),
        .wrap     (wrap),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        bit wrp;
        bit bsy;
        bit dn;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    int m_st, m_cnt, m_lim, m_wrap;
    bit m_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_lim = (1 << W) - 1; m_mode = 1'b0; m_wrap = 0;
    endtask

    // Behavioural reference: state after one rising edge with the given inputs.
    task automatic model_step(input bit clr, stp, sta, cv, input int cl, input bit cm);
        m_wrap = 0;
        if (clr) begin
            m_st = M_IDLE; m_cnt = 0;
        end else if (m_st == M_IDLE || m_st == M_DONE) begin
            if (cv) begin
                m_lim = cl; m_mode = cm; m_cnt = 0; m_st = M_IDLE;
            end
            if (sta && !stp) begin
                m_st = M_RUN; m_cnt = 0;
            end
        end else if (m_st == M_RUN) begin
            if (m_cnt == m_lim) begin
                m_cnt = 0; m_wrap = 1;
                if (stp) m_st = M_PAUSE;
                else if (m_mode) m_st = M_DONE;
            end else begin
                m_cnt = m_cnt + 1;
                if (stp) m_st = M_PAUSE;
            end
        end else if (sta && !stp) begin
            m_st = M_RUN;
        end
    endtask

    task automatic cycle(input bit clr, stp, sta, cv, input int cl, input bit cm);
        exp_t e;
        @(negedge clock);
        clear = clr; stop = stp; start = sta; cfg_valid = cv; cfg_limit = W'(cl); cfg_mode = cm;
        model_step(clr, stp, sta, cv, cl, cm);
        e.cnt = m_cnt;
        e.wrp = (m_wrap != 0);
        e.bsy = (m_st == M_RUN || m_st == M_PAUSE);
        e.dn  = (m_st == M_DONE);
        e.rdy = (m_st == M_IDLE || m_st == M_DONE);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clock);
        #3;
    endtask

    // Monitor: outputs are valid every cycle, so each edge retires one expectation.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("count", 32'(count), 32'(mon_e.cnt));
            chk("wrap", 32'(wrap), 32'(mon_e.wrp));
            chk("busy", 32'(busy), 32'(mon_e.bsy));
            chk("done", 32'(done), 32'(mon_e.dn));
            chk("cfg_ready", 32'(cfg_ready), 32'(mon_e.rdy));
        end
    end

    initial begin
        reset = 1'b1;
        cfg_valid = 0; cfg_limit = '0; cfg_mode = 0; start = 0; stop = 0; clear = 0;
        model_reset();
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_wrap", 32'(wrap), 0);
        @(negedge clock);
        reset = 1'b0;

        // start held from reset: default limit 7, wrap eight edges after RUN entry
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0, 0);
        settle();
        chk("dflt_wrap", 32'(wrap), 1);
        chk("dflt_wrap_cnt", 32'(count), 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, 1, 0, 0, 0);

        // one-shot, limit 4
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 4, 1);
        cycle(0, 0, 1, 0, 0, 0);
        idle(5);
        settle();
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_ready", 32'(cfg_ready), 1);
        idle(10);
        settle();
        chk("os_hold_cnt", 32'(count), 0);

        // pause at 3 for five cycles, then resume
        cycle(0, 0, 0, 1, 7, 0);
        cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8 && m_cnt != 2; i++) cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        settle();
        chk("pause_cnt", 32'(count), 3);
        chk("pause_wrap", 32'(wrap), 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("resume_cnt", 32'(count), 4);

        // cfg offered during RUN is refused; old limit 7 stays in force
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 2, 1);
        settle();
        chk("run_ready", 32'(cfg_ready), 0);
        for (int i = 0; i < 8 && m_cnt != 7; i++) cycle(0, 0, 0, 1, 2, 1);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("old_lim_wrap", 32'(wrap), 1);
        chk("old_lim_cnt", 32'(count), 0);

        // asynchronous reset at count 5
        for (int i = 0; i < 8 && m_cnt != 5; i++) cycle(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_wrap", 32'(wrap), 0);
        #1;
        reset = 1'b0;
        model_reset();
        idle(3);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0, 0);
        settle();
        chk("post_rst_lim7", 32'(wrap), 1);

        // limit 0 periodic, then stop
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0);
        idle(4);
        settle();
        chk("lim0_wrap", 32'(wrap), 1);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        settle();
        chk("lim0_stop_wrap", 32'(wrap), 0);
        chk("lim0_stop_busy", 32'(busy), 1);

        // one-shot final wrap coincides with stop: PAUSE wins over DONE
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        settle();
        chk("os_stop_done", 32'(done), 0);
        chk("os_stop_busy", 32'(busy), 1);
        chk("os_stop_wrap", 32'(wrap), 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clock);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 3, counter width in bits (default gives a mod-8 counter).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: cfg_valid  input  1  configuration offered.
REQ-005 SHALL have port: cfg_ready  output  1  configuration can be accepted.
REQ-006 SHALL have port: cfg_limit  input  WIDTH  terminal count; the count runs 0..cfg_limit.
REQ-007 SHALL have port: cfg_mode  input  1  0 = periodic, 1 = one-shot.
REQ-008 SHALL have port: start  input  1  level-sampled run/resume request.
REQ-009 SHALL have port: stop  input  1  pause request.
REQ-010 SHALL have port: clear  input  1  synchronous abort to IDLE.
REQ-011 SHALL have port: count  output  WIDTH  current count value.
REQ-012 SHALL have port: wrap  output  1  one-cycle pulse on each limit->0 transition.
REQ-013 SHALL have port: busy  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port: done  output  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-016 SHALL assert cfg_ready exactly in IDLE or DONE; a transfer occurs on cfg_valid & cfg_ready at a rising edge.
REQ-017 A transfer SHALL latch limit and mode and set count to 0; in DONE it SHALL also return the FSM to IDLE unless start is also high.
REQ-018 SHALL ignore cfg_valid in RUN or PAUSE; no change to limit, mode or count.
REQ-019 SHALL prioritise clear > stop > start when several are asserted on the same edge.
REQ-020 clear SHALL go to IDLE with count = 0 and keep the latched limit and mode.
REQ-021 Transitions:
- IDLE/DONE --start--> RUN, with count = 0.
- RUN --stop--> PAUSE.
- PAUSE --start--> RUN.
- start in RUN, stop in PAUSE, stop in IDLE/DONE: ignored.
REQ-022 In RUN, count SHALL increment by 1 per clock; the first increment occurs on the edge after the edge that entered RUN.
REQ-023 In RUN with count == limit, the next edge SHALL set count to 0 and register wrap = 1 for exactly that one following cycle.
REQ-024 In one-shot mode, that wrap edge SHALL also move the FSM to DONE; count holds 0 in DONE.
REQ-025 In PAUSE, count SHALL hold its value and wrap SHALL be 0.
REQ-026 With limit = 0 in periodic RUN, count SHALL stay 0 and wrap SHALL be 1 every cycle.
REQ-027 All arithmetic SHALL be unsigned WIDTH-bit; count never exceeds limit.
REQ-028 A stop on the same edge as a wrap SHALL take effect: the FSM enters PAUSE with count = 0, and wrap still pulses.
REQ-029 In one-shot mode, when stop and the final wrap coincide, stop SHALL win: the FSM enters PAUSE, count = 0, and DONE is not entered.

Reset
REQ-030 Reset SHALL immediately force:
- FSM = IDLE, count = 0, wrap = 0, busy = 0, done = 0, cfg_ready = 1;
- limit = 2^WIDTH-1, mode = periodic.
REQ-031 Reset asserted mid-operation SHALL abort with no residual pulse after release; the first RUN requires a new start.

Structure
REQ-032 Package counter_pkg SHALL hold:
- the state enumeration;
- mode constants MODE_PERIODIC = 0 and MODE_ONESHOT = 1.
REQ-033 The counting datapath SHALL be sub-module mod_counter (enable, zero, limit, count, wrap); counter_ctrl holds the FSM and configuration registers.
REQ-034 Outputs SHALL be registered or decoded from state registers only.

Verification (WIDTH = 3)
REQ-035 Reset, no cfg, start held, 20 cycles -> count 0,1..7,0,1..; wrap high in the cycles where count = 0 after a wrap (cycle 8 and cycle 16 after RUN entry).
REQ-036 cfg limit = 4, one-shot, start -> count 0,1,2,3,4,0; done = 1, busy = 0, cfg_ready = 1; count stays 0 for 10 cycles.
REQ-037 stop at count = 3 for 5 cycles, then start -> count holds 3 throughout; count = 4 one cycle after RUN re-entry; no wrap while paused.
REQ-038 cfg_valid with limit = 2 during RUN -> cfg_ready = 0; wrapping continues at the old limit 7.
REQ-039 reset pulsed at count = 5 mid-run -> count = 0 and busy = 0 without waiting for a clock edge; limit = 7 after release.
REQ-040 limit = 0, periodic, start -> count = 0 and wrap = 1 every cycle; stop -> wrap = 0 the following cycle.
